// File: rtl/conv_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_frame_ctrl_if
// Description : Handshake/status bundle between the frame sequencer and its
//               surroundings (input pixel FIFO, convolution datapath, output
//               buffer).
//   start              - begin a frame (honoured only while idle)
//   in_valid           - input FIFO holds a pixel
//   is_OutBuff_notFull - output buffer can take one result
//   rd_en              - pop the input FIFO this cycle
//   shift_en           - advance line buffers / window registers this cycle
//   valid_out          - datapath sum is a valid result this cycle
//   col / row          - position of the next pixel to be accepted
//   busy               - frame in progress
//   done               - one-cycle frame-end pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_frame_ctrl_if #(
   parameter int COL_W = 16,
   parameter int ROW_W = 16
);
   logic             start;
   logic             in_valid;
   logic             is_OutBuff_notFull;
   logic             rd_en;
   logic             shift_en;
   logic             valid_out;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             busy;
   logic             done;

   // Environment side: drives the requests, observes the sequencer.
   modport master (
      output start, in_valid, is_OutBuff_notFull,
      input  rd_en, shift_en, valid_out, col, row, busy, done
   );

   // Sequencer side.
   modport slave (
      input  start, in_valid, is_OutBuff_notFull,
      output rd_en, shift_en, valid_out, col, row, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/conv_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv_frame_ctrl
// Description : Frame sequencer for a 3x3 convolution datapath. Accepts one
//               pixel per cycle when the input FIFO is non-empty and the
//               output buffer has room, tracks the row/column of the next
//               pixel, flags window results only once a full 3x3
//               neighbourhood is present, and pulses done at frame end.
// Ports       : Clk   - clock, rising edge
//               nRst  - asynchronous active-low reset
//               bus   - conv_frame_ctrl_if.slave (start, in_valid,
//                       is_OutBuff_notFull in; rd_en, shift_en, valid_out,
//                       col, row, busy, done out)
// Revision    : 1.0 - initial release
// ============================================================================
module conv_frame_ctrl #(
   parameter int IMG_WIDTH  = 8,
   parameter int IMG_HEIGHT = 8,
   parameter int COL_W      = 16,
   parameter int ROW_W      = 16
) (
   input  wire logic          Clk,
   input  wire logic          nRst,
   conv_frame_ctrl_if.slave   bus
);

   localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] c_col_two  = COL_W'(2);
   localparam logic [ROW_W-1:0] c_row_two  = ROW_W'(2);
   localparam logic [COL_W-1:0] c_col_one  = COL_W'(1);
   localparam logic [ROW_W-1:0] c_row_one  = ROW_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             valid_out_q, valid_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             w_accept;

   // A full output buffer stalls even a masked window: the whole datapath
   // freezes together so results are never dropped.
   assign w_accept = (state_q == S_RUN) && bus.in_valid && bus.is_OutBuff_notFull;

   assign bus.rd_en     = w_accept;
   assign bus.shift_en  = w_accept;
   assign bus.valid_out = valid_out_q;
   assign bus.col       = col_q;
   assign bus.row       = row_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      valid_out_d = 1'b0;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_RUN;
               col_d   = '0;
               row_d   = '0;
            end
         end
         S_RUN: begin
            if (w_accept) begin
               // Accepting (r,c) completes the window centred on (r-1,c-1);
               // columns 0/1 and rows 0/1 are masked, which also hides
               // windows straddling a row wrap and stale line-buffer data.
               valid_out_d = (row_q >= c_row_two) && (col_q >= c_col_two);
               if (col_q == c_col_last) begin
                  col_d = '0;
                  if (row_q == c_row_last) begin
                     row_d   = '0;
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     row_d = row_q + c_row_one;
                  end
               end else begin
                  col_d = col_q + c_col_one;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Registered busy tracks the state being entered, so it rises on the
      // start edge and falls on the edge that accepts the last pixel.
      busy_d = (state_d == S_RUN);
   end

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         state_q     <= S_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         valid_out_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         valid_out_q <= valid_out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_frame_ctrl
// Description : Scoreboard bench for conv_frame_ctrl (8x8 frame). A reference
//               model counts accepted pixels per frame and queues the
//               expected per-accept response; a monitor checks outputs every
//               falling edge against the model and the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_frame_ctrl;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int CW = 16;
   localparam int RW = 16;

   logic Clk  = 1'b0;
   logic nRst = 1'b0;

   always #5 Clk = ~Clk;

   conv_frame_ctrl_if #(.COL_W(CW), .ROW_W(RW)) bus ();

   conv_frame_ctrl #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .COL_W     (CW),
      .ROW_W     (RW)
   ) dut (
      .Clk (Clk),
      .nRst(nRst),
      .bus (bus)
   );

   typedef struct {
      int eno;     // edge at which the accept happened
      bit valid;   // window result expected after that edge
      bit done;    // frame-end pulse expected after that edge
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A frame is simply a count of accepted pixels; position is n/W, n%W.
   int edge_cnt = 0;
   bit m_run    = 1'b0;
   bit m_cool   = 1'b0;   // frame-end cycle in which start is ignored
   int m_n      = 0;

   always @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         m_run  = 1'b0;
         m_cool = 1'b0;
         m_n    = 0;
         sb.delete();
      end else begin
         edge_cnt++;
         if (m_cool) begin
            m_cool = 1'b0;
         end else if (!m_run) begin
            if (bus.start === 1'b1) begin
               m_run = 1'b1;
               m_n   = 0;
            end
         end else if (bus.in_valid && bus.is_OutBuff_notFull) begin
            sb.push_back('{eno: edge_cnt,
                           valid: ((m_n / W) >= 2) && ((m_n % W) >= 2),
                           done: (m_n == W*H - 1)});
            m_n++;
            if (m_n == W*H) begin
               m_run  = 1'b0;
               m_cool = 1'b1;
               m_n    = 0;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   int mon_acc  = 0;
   int mon_vo   = 0;
   int mon_done = 0;
   bit e_valid, e_done, e_rd;

   always @(negedge Clk) begin
      chk("col",  32'(bus.col),  32'(m_n % W));
      chk("row",  32'(bus.row),  32'(m_n / W));
      chk("busy", 32'(bus.busy), 32'(m_run));
      e_rd = m_run && bus.in_valid && bus.is_OutBuff_notFull;
      chk("rd_en",    32'(bus.rd_en),    32'(e_rd));
      chk("shift_en", 32'(bus.shift_en), 32'(e_rd));
      e_valid = 1'b0;
      e_done  = 1'b0;
      if (sb.size() > 0 && sb[0].eno == edge_cnt) begin
         e_valid = sb[0].valid;
         e_done  = sb[0].done;
         void'(sb.pop_front());
      end
      chk("valid_out", 32'(bus.valid_out), 32'(e_valid));
      chk("done",      32'(bus.done),      32'(e_done));
      if (bus.rd_en === 1'b1)     mon_acc++;
      if (bus.valid_out === 1'b1) mon_vo++;
      if (bus.done === 1'b1)      mon_done++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_inputs(input int mode, input int k);
      case (mode)
         0: begin bus.in_valid = 1'b1; bus.is_OutBuff_notFull = 1'b1; end
         1: begin bus.in_valid = (k % 2 == 0); bus.is_OutBuff_notFull = 1'b1; end
         2: begin
            bus.in_valid           = ($urandom_range(0, 3) != 0);
            bus.is_OutBuff_notFull = ($urandom_range(0, 4) != 0);
         end
         default: begin
            // output buffer full for five cycles in the middle of row 4
            bus.in_valid           = 1'b1;
            bus.is_OutBuff_notFull = !(k >= 35 && k < 40);
         end
      endcase
   endtask

   task automatic run_frame(input int mode, input bit hold_start);
      int a0, v0, d0, k;
      a0 = mon_acc;
      v0 = mon_vo;
      d0 = mon_done;
      bus.start = 1'b1;
      tick();
      if (!hold_start) bus.start = 1'b0;
      k = 0;
      while (mon_done == d0 && k < 2000) begin
         set_inputs(mode, k);
         tick();
         k++;
      end
      chk("frame_timeout", 32'(k < 2000), 32'd1);
      bus.start              = 1'b0;
      bus.in_valid           = 1'b1;
      bus.is_OutBuff_notFull = 1'b1;
      tick();
      tick();
      chk("accepts", 32'(mon_acc - a0), 32'(W*H));
      chk("results", 32'(mon_vo - v0),  32'((W-2)*(H-2)));
      chk("dones",   32'(mon_done - d0), 32'd1);
   endtask

   initial begin
      bus.start              = 1'b0;
      bus.in_valid           = 1'b1;
      bus.is_OutBuff_notFull = 1'b1;
      nRst = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      nRst = 1'b1;
      tick();

      run_frame(0, 1'b0);   // unstalled
      run_frame(1, 1'b0);   // input empty every other cycle
      run_frame(3, 1'b0);   // output-full stall mid row 4
      run_frame(0, 1'b1);   // start held high through the frame
      run_frame(0, 1'b0);   // back-to-back restart from idle

      // asynchronous reset after 20 accepts (pixel 20 is a valid window)
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (20) tick();
      #1;
      nRst = 1'b0;
      #1;
      chk("rst_rd_en",     32'(bus.rd_en),     32'd0);
      chk("rst_shift_en",  32'(bus.shift_en),  32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_col",       32'(bus.col),       32'd0);
      chk("rst_row",       32'(bus.row),       32'd0);
      chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
      chk("rst_done",      32'(bus.done),      32'd0);
      tick();
      tick();
      nRst = 1'b1;
      tick();
      run_frame(0, 1'b0);

      for (int i = 0; i < 3; i++) begin
         run_frame(2, 1'($urandom_range(0, 1)));
      end

      tick();
      tick();
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
